// File: rtl/conv_weight_loader.sv
// conv_weight_loader
//   Write-side master for the conv block weight/bias register interface.
//   Accepts a valid/ready stream of signed weight words and writes each word
//   to the next sequential address. The stream carries all kernels first
//   (row-major, kx fastest) and then the biases. The loader checks the
//   stream length against the layer geometry and raises done when the layer
//   is fully loaded, or err when the length is wrong.
//
// Ports
//   clk, rst                  single clock, synchronous active-high reset
//   start                     one-cycle pulse, begins a layer load (ignored in LOAD)
//   s_data/s_valid/s_last     input word stream
//   s_ready                   high while loading
//   weights_mem_in_data       sign-extended word (held when no write)
//   weights_mem_in_addr       write address (held when no write)
//   weights_mem_in_kernel_wr  write strobe, one cycle after each handshake
//   busy / done / err         mutually exclusive load status
module conv_weight_loader #(
  parameter int WEIGHT_WIDTH     = 10,
  parameter int KERNEL_DIMENSION = 3,
  parameter int IN_DIMENSION     = 1,
  parameter int OUT_DIMENSION    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WEIGHT_WIDTH-1:0] s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic [31:0]             weights_mem_in_data,
  output logic [31:0]             weights_mem_in_addr,
  output logic                    weights_mem_in_kernel_wr,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int KERN_WORDS  = OUT_DIMENSION * IN_DIMENSION * KERNEL_DIMENSION * KERNEL_DIMENSION;
  localparam int TOTAL_WORDS = KERN_WORDS + OUT_DIMENSION;
  localparam int CNT_W       = $clog2(TOTAL_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s_ready_q, s_ready_d;
  logic             wr_q, wr_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             hs;
  logic [31:0]      data_sext;

  // Sign extension: the top input bit fills every bit above the word.
  for (genvar gi = 0; gi < 32; gi++) begin : g_sext
    if (gi < WEIGHT_WIDTH) begin : g_low
      assign data_sext[gi] = s_data[gi];
    end else begin : g_high
      assign data_sext[gi] = s_data[WEIGHT_WIDTH-1];
    end
  end

  // s_ready_q is only ever high in LOAD, so this is the only handshake qualifier.
  assign hs = s_valid & s_ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = 1'b0;

    case (state_q)
      LOAD: begin
        if (hs) begin
          wr_d   = 1'b1;
          addr_d = 32'(cnt_q);
          data_d = data_sext;
          cnt_d  = cnt_q + CNT_W'(1);
          // The final word is always written; only the next state differs.
          if (cnt_q == LAST_IDX) begin
            state_d = s_last ? DONE : ERR;
          end else if (s_last) begin
            state_d = ERR;
          end
        end
      end
      default: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
    endcase

    // Status and ready are decoded from the next state so they are registered
    // alongside it and can never overlap.
    s_ready_d = (state_d == LOAD);
    busy_d    = (state_d == LOAD);
    done_d    = (state_d == DONE);
    err_d     = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign s_ready                  = s_ready_q;
  assign weights_mem_in_data      = data_q;
  assign weights_mem_in_addr      = addr_q;
  assign weights_mem_in_kernel_wr = wr_q;
  assign busy                     = busy_q;
  assign done                     = done_q;
  assign err                      = err_q;

endmodule

// File: tb/tb_conv_weight_loader.sv
// Directed bench for conv_weight_loader with default geometry
// (KERN_WORDS = 36, TOTAL_WORDS = 40).
module tb_conv_weight_loader;

  localparam int W     = 10;
  localparam int TOTAL = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic [31:0]   wdata;
  logic [31:0]   waddr;
  logic          wr;
  logic          busy;
  logic          done;
  logic          err;

  conv_weight_loader dut (
    .clk                      (clk),
    .rst                      (rst),
    .start                    (start),
    .s_data                   (s_data),
    .s_valid                  (s_valid),
    .s_last                   (s_last),
    .s_ready                  (s_ready),
    .weights_mem_in_data      (wdata),
    .weights_mem_in_addr      (waddr),
    .weights_mem_in_kernel_wr (wr),
    .busy                     (busy),
    .done                     (done),
    .err                      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write monitor: logs every write strobe seen between clock edges.
  int          cyc = 0;
  int          wr_cnt = 0;
  int          mutex_bad = 0;
  logic [31:0] log_addr [0:511];
  logic [31:0] log_data [0:511];
  int          log_cyc  [0:511];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr === 1'b1 && wr_cnt < 512) begin
      log_addr[wr_cnt] = waddr;
      log_data[wr_cnt] = wdata;
      log_cyc[wr_cnt]  = cyc;
      $display("write #%0d addr=%0d data=0x%08h", wr_cnt, waddr, wdata);
      wr_cnt = wr_cnt + 1;
    end
    if (!rst && (int'(busy) + int'(done) + int'(err)) > 1) mutex_bad = mutex_bad + 1;
  end

  logic [W-1:0] wvals [0:TOTAL-1];

  task automatic fill_ramp();
    for (int i = 0; i < TOTAL; i++) wvals[i] = W'(i);
  endtask

  // All stimulus changes 1 time unit after a rising edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Sends n words; last_at marks s_last (-1 = never), start_at pulses start
  // alongside that word, gap inserts one idle cycle before each word.
  task automatic send(input int n, input int last_at, input bit gap, input int start_at);
    for (int i = 0; i < n; i++) begin
      int budget;
      if (gap) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = wvals[i];
      s_last  = (i == last_at);
      start   = (i == start_at);
      budget  = 50;
      @(negedge clk);
      while (s_ready !== 1'b1 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (budget == 0) begin
        check("send_timeout", 32'(i), 32'hFFFF_FFFF);
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts logged writes from base whose address/data differ from the ramp.
  function automatic int ramp_bad(input int base, input int n);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      if (log_addr[base+k] !== 32'(k) || log_data[base+k] !== 32'(k)) bad++;
    end
    return bad;
  endfunction

  int base;

  initial begin
    fill_ramp();

    // Reset with s_valid high: everything quiet.
    s_valid = 1'b1;
    wait_cycles(2);
    @(negedge clk);
    check("rst_wr",      32'(wr),      32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_addr",    waddr,        32'd0);
    check("rst_data",    wdata,        32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    s_valid = 1'b1;
    wait_cycles(2);   // valid in IDLE must not be consumed
    s_valid = 1'b0;
    check("idle_no_wr", 32'(wr_cnt), 32'd0);

    // Continuous load 0..39.
    base = wr_cnt;
    pulse_start();
    send(TOTAL, TOTAL - 1, 1'b0, -1);
    @(negedge clk);
    check("cont_done",  32'(done),  32'd1);
    check("cont_busy",  32'(busy),  32'd0);
    check("cont_err",   32'(err),   32'd0);
    check("cont_ready", 32'(s_ready), 32'd0);
    wait_cycles(3);
    check("cont_count", 32'(wr_cnt - base), 32'd40);
    check("cont_ramp",  32'(ramp_bad(base, TOTAL)), 32'd0);
    check("cont_span",  32'(log_cyc[base+TOTAL-1] - log_cyc[base]), 32'd39);

    // Sign extension and bias placement.
    wvals[36] = 10'h3FF;
    wvals[39] = 10'h200;
    base = wr_cnt;
    pulse_start();
    send(TOTAL, TOTAL - 1, 1'b0, -1);
    wait_cycles(3);
    check("sext_count", 32'(wr_cnt - base), 32'd40);
    check("sext_addr36", log_addr[base+36], 32'd36);
    check("sext_data36", log_data[base+36], 32'hFFFF_FFFF);
    check("sext_addr39", log_addr[base+39], 32'd39);
    check("sext_data39", log_data[base+39], 32'hFFFF_FE00);
    check("sext_data35", log_data[base+35], 32'd35);
    check("sext_done",  32'(done), 32'd1);
    check("hold_addr",  waddr, 32'd39);
    check("hold_data",  wdata, 32'hFFFF_FE00);
    fill_ramp();

    // Gapped valid.
    base = wr_cnt;
    pulse_start();
    send(TOTAL, TOTAL - 1, 1'b1, -1);
    wait_cycles(3);
    check("gap_count", 32'(wr_cnt - base), 32'd40);
    check("gap_ramp",  32'(ramp_bad(base, TOTAL)), 32'd0);
    check("gap_done",  32'(done), 32'd1);

    // Early last on word 20.
    base = wr_cnt;
    pulse_start();
    send(21, 20, 1'b0, -1);
    @(negedge clk);
    check("early_err",   32'(err),     32'd1);
    check("early_ready", 32'(s_ready), 32'd0);
    check("early_done",  32'(done),    32'd0);
    wait_cycles(3);
    check("early_count", 32'(wr_cnt - base), 32'd21);
    check("early_ramp",  32'(ramp_bad(base, 21)), 32'd0);

    // Restart after error begins again at address 0.
    base = wr_cnt;
    pulse_start();
    @(negedge clk);
    check("restart_err",  32'(err),  32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    send(1, -1, 1'b0, -1);
    wait_cycles(2);
    check("restart_addr", log_addr[base], 32'd0);

    // Reset mid-load aborts.
    rst = 1'b1;
    s_valid = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    s_valid = 1'b0;
    base = wr_cnt;
    wait_cycles(3);
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_no_wr", 32'(wr_cnt - base), 32'd0);

    // Missing last, with a start pulse on word 10 that must be ignored.
    base = wr_cnt;
    pulse_start();
    send(TOTAL, -1, 1'b0, 10);
    @(negedge clk);
    check("miss_err",  32'(err),  32'd1);
    check("miss_done", 32'(done), 32'd0);
    s_valid = 1'b1;   // extra words must not be consumed
    wait_cycles(4);
    s_valid = 1'b0;
    check("miss_count", 32'(wr_cnt - base), 32'd40);
    check("miss_ramp",  32'(ramp_bad(base, TOTAL)), 32'd0);

    check("status_mutex", 32'(mutex_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_weight_loader.md
Name: conv_weight_loader

Overview:
- Write-side master for the conv block weight/bias register interface (weights_mem_in_data / weights_mem_in_addr / weights_mem_in_kernel_wr).
- Takes a valid/ready word stream, normally from a weight ROM reader or a host bridge, and issues one write per word at sequential addresses.
- Checks the stream length against the layer geometry and flags when the layer is fully loaded, so the pixel pipeline can be released.

Parameters:
- WEIGHT_WIDTH, 10: width of one weight/bias word, signed fixed point.
- KERNEL_DIMENSION, 3: kernel side K.
- IN_DIMENSION, 1: input channels.
- OUT_DIMENSION, 4: output channels.
- Derived KERN_WORDS = OUT_DIMENSION*IN_DIMENSION*K*K.
- Derived TOTAL_WORDS = KERN_WORDS + OUT_DIMENSION.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a layer load.
- s_data  in  WEIGHT_WIDTH  signed weight/bias word.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks the final word of the stream.
- s_ready  out  1  loader accepts a word this cycle.
- weights_mem_in_data  out  int (32)  sign-extended word.
- weights_mem_in_addr  out  int (32)  write address.
- weights_mem_in_kernel_wr  out  1  write strobe.
- busy  out  1  load in progress.
- done  out  1  layer loaded correctly.
- err  out  1  stream length mismatch.

Behaviour:
- Reset: all outputs 0, state IDLE, word counter 0. Reset mid-load aborts immediately with no further writes; already-written words stay in the target.
- Address map, identical to the target's packing:
  - Kernel word for (row, col, ky, kx) goes to addr ((row*IN_DIMENSION+col)*K+ky)*K+kx.
  - Bias[row] goes to addr KERN_WORDS+row.
  - The upstream stream therefore delivers all kernels first (row-major, kx fastest), then the biases.
- FSM states: IDLE, LOAD, DONE, ERR.
- IDLE / DONE / ERR:
  - s_ready=0.
  - start=1 moves to LOAD next cycle, clears done and err, and sets the counter to 0.
  - busy=0.
- LOAD:
  - busy=1 and s_ready=1.
  - Handshake is s_valid&s_ready.
  - On a handshake, the next cycle gives weights_mem_in_kernel_wr=1, addr=counter, data=sign-extended s_data; the counter then increments.
  - Write latency is exactly 1 cycle after the handshake. wr is 0 on every cycle without a preceding handshake.
  - s_valid is sampled only while s_ready=1.
- Completion:
  - Handshake with counter==TOTAL_WORDS-1 and s_last=1: next state DONE, done=1 held.
  - Handshake with counter==TOTAL_WORDS-1 and s_last=0: next state ERR, err=1. The word is still written; s_ready drops, so extra words are not consumed.
  - Handshake with s_last=1 and counter<TOTAL_WORDS-1: the word is written, then next state ERR.
- start while in LOAD is ignored; it does not restart the load.
- start and a handshake in the same IDLE cycle: the handshake does not count, because s_ready=0 in IDLE.
- busy, done and err are mutually exclusive at all times.
- Address and data outputs hold their last value when wr=0.
- Sign extension: bit WEIGHT_WIDTH-1 is replicated into bits 31..WEIGHT_WIDTH. No saturation and no scaling.
- Throughput: 1 word/cycle. TOTAL_WORDS words with continuous valid take TOTAL_WORDS cycles in LOAD.

Test Plan (defaults, TOTAL_WORDS=40, KERN_WORDS=36):
- Reset check: assert rst for 2 cycles with s_valid=1 -> all outputs 0, no wr pulses.
- Continuous load: start, then 40 words with values 0..39 and s_last on word 39 -> wr high 40 consecutive cycles, addr 0..39 each carrying data equal to addr, then done=1, busy=0.
- Sign extension and bias placement: word 36 = 10'h3FF, word 39 = 10'h200 -> addr 36 data 32'hFFFFFFFF, addr 39 data 32'hFFFFFE00.
- Gapped valid: s_valid toggling 1/0 every cycle -> 40 writes with addresses strictly incrementing, no duplicate or skipped address, done after the 40th.
- Early last: s_last on word 20 -> 21 writes (addr 0..20), err=1, s_ready=0. A following start begins a fresh load at addr 0 with err cleared.
- Missing last: 40 words with s_last=0 -> err=1 after addr 39. Additionally, start pulsed mid-load (at word 10) -> ignored, addresses continue from 11 with no restart.
